// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared state encoding and word-length helper for the shift register readers/writers
package shift_reg_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LOW, SHIFT_HIGH, DONE} state_t;
  function automatic int word_bits(input int data_width);
    return 1 << data_width;
  endfunction
endpackage

// File: rtl/shift_reg_input_if.sv
// shift_reg_input_if: start/serial/result signals of shift_reg_input
//   i_enable_toggle start request, i_data_val serial Q7 data,
//   o_load_n/o_data_clock register controls, o_value/o_valid/o_busy result.
//   master = reader block, slave = its user (board top or bench).
interface shift_reg_input_if #(parameter int N = 16);
  logic         i_enable_toggle;
  logic         i_data_val;
  logic         o_load_n;
  logic         o_data_clock;
  logic [N-1:0] o_value;
  logic         o_valid;
  logic         o_busy;
  modport master (
    input  i_enable_toggle, i_data_val,
    output o_load_n, o_data_clock, o_value, o_valid, o_busy
  );
  modport slave (
    output i_enable_toggle, i_data_val,
    input  o_load_n, o_data_clock, o_value, o_valid, o_busy
  );
endinterface

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: 2-flop synchronizer for one asynchronous input
//   i_clk clock, i_reset_n async active-low reset, i_d async input, o_q synchronized output.
module bit_synchronizer (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_sync;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  assign o_q = r_sync;
endmodule

// File: rtl/shift_reg_input.sv
// shift_reg_input: reads a 74HC165-style PISO register into a parallel word
//   i_clk system clock, i_reset_n async active-low reset,
//   bus (shift_reg_input_if.master): i_enable_toggle rising edge starts a read,
//   i_data_val serial data, o_load_n/o_data_clock register controls,
//   o_value last accepted word (MSB shifted first), o_valid one-cycle strobe, o_busy.
//   Optional SHIFT_REG_INPUT_DEBOUNCE_EN: accept a word only when two reads in a row match.
module shift_reg_input
  import shift_reg_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int HALF_PERIOD = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  shift_reg_input_if.master bus
);
  localparam int N  = word_bits(DATA_WIDTH);
  localparam int PW = $clog2(HALF_PERIOD);
  localparam logic [PW-1:0]         PH_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [DATA_WIDTH-1:0] IDX_LAST = DATA_WIDTH'(N - 1);
  state_t                r_state, w_next;
  logic [PW-1:0]         r_phase;
  logic [DATA_WIDTH-1:0] r_index;
  // Only the low N-1 bits are kept; the final sample is appended in w_raw_next.
  logic [N-2:0]          r_raw;
  logic [N-1:0]          r_value, w_raw_next;
  logic                  r_valid, r_en_q, w_data_sync, w_start, w_phase_end, w_last_sample, w_accept;
  bit_synchronizer u_sync (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_d      (bus.i_data_val),
    .o_q      (w_data_sync)
  );
  assign w_start       = bus.i_enable_toggle & ~r_en_q;
  assign w_phase_end   = r_phase == PH_LAST;
  assign w_raw_next    = {r_raw, w_data_sync};
  assign w_last_sample = (r_state == SHIFT_LOW) && w_phase_end && (r_index == IDX_LAST);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = w_start ? LOAD : IDLE;
      LOAD:       w_next = w_phase_end ? SHIFT_LOW : LOAD;
      SHIFT_LOW:  w_next = !w_phase_end ? SHIFT_LOW : (r_index == IDX_LAST) ? DONE : SHIFT_HIGH;
      SHIFT_HIGH: w_next = w_phase_end ? SHIFT_LOW : SHIFT_HIGH;
      DONE:       w_next = w_start ? LOAD : IDLE;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_index <= '0;
      r_raw   <= '0;
      r_en_q  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_en_q  <= bus.i_enable_toggle;
      r_phase <= (w_next != r_state || r_state == IDLE || r_state == DONE) ? '0 : r_phase + 1'b1;
      if (r_state == LOAD)
        r_index <= '0;
      else if (r_state == SHIFT_HIGH && w_phase_end)
        r_index <= r_index + 1'b1;
      if (r_state == SHIFT_LOW && w_phase_end)
        r_raw <= w_raw_next[N-2:0];
    end
`ifdef SHIFT_REG_INPUT_DEBOUNCE_EN
  logic [N-1:0] r_prev_raw;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n)
      r_prev_raw <= '0;
    else if (w_last_sample)
      r_prev_raw <= w_raw_next;
  assign w_accept = w_raw_next == r_prev_raw;
`else
  assign w_accept = 1'b1;
`endif
  // The word is captured on the final sample edge so o_value is already
  // stable during the DONE cycle in which o_valid is high.
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_value <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_last_sample & w_accept;
      if (w_last_sample & w_accept)
        r_value <= w_raw_next;
    end
  assign bus.o_load_n     = r_state != LOAD;
  assign bus.o_data_clock = r_state == SHIFT_HIGH;
  assign bus.o_busy       = r_state == LOAD || r_state == SHIFT_LOW || r_state == SHIFT_HIGH;
  assign bus.o_value      = r_value;
  assign bus.o_valid      = r_valid;
endmodule

// File: tb/tb_shift_reg_input.sv
// tb_shift_reg_input: directed checks of shift_reg_input against a behavioural 165 model
`timescale 1ns/1ps
module tb_shift_reg_input;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  shift_reg_input_if #(.N(16)) bus_a ();
  shift_reg_input_if #(.N(8))  bus_b ();
  shift_reg_input #(.DATA_WIDTH(4), .HALF_PERIOD(4)) dut_a (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_a));
  shift_reg_input #(.DATA_WIDTH(3), .HALF_PERIOD(3)) dut_b (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_b));
  logic [15:0] par_a = '0, sr_a = '0;
  logic [7:0]  par_b = '0, sr_b = '0;
  logic        dq_a = 1'b0, dq_b = 1'b0;
  always @(posedge clk) begin
    if (!bus_a.o_load_n) sr_a <= par_a;
    else if (bus_a.o_data_clock && !dq_a) sr_a <= {sr_a[14:0], 1'b0};
    dq_a <= bus_a.o_data_clock;
    if (!bus_b.o_load_n) sr_b <= par_b;
    else if (bus_b.o_data_clock && !dq_b) sr_b <= {sr_b[6:0], 1'b0};
    dq_b <= bus_b.o_data_clock;
  end
  assign bus_a.i_data_val = sr_a[15];
  assign bus_b.i_data_val = sr_b[7];
  bit sel = 1'b0;
  logic        obs_load_n, obs_dclk, obs_valid, obs_busy;
  logic [15:0] obs_value;
  assign obs_load_n = sel ? bus_b.o_load_n     : bus_a.o_load_n;
  assign obs_dclk   = sel ? bus_b.o_data_clock : bus_a.o_data_clock;
  assign obs_valid  = sel ? bus_b.o_valid      : bus_a.o_valid;
  assign obs_busy   = sel ? bus_b.o_busy       : bus_a.o_busy;
  assign obs_value  = sel ? {8'h00, bus_b.o_value} : bus_a.o_value;
  int checks = 0, errors = 0;
  int res_n, res_load, res_rises, res_k[2];
  logic [15:0] res_v[2], res_end;
  logic res_busy1, res_busy_v;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tog(input bit s, input logic v);
    if (s) bus_b.i_enable_toggle = v;
    else bus_a.i_enable_toggle = v;
  endtask
  task automatic set_par(input bit s, input logic [15:0] p);
    if (s) par_b = p[7:0];
    else par_a = p;
  endtask
  task automatic run_read(input bit s, input logic [15:0] p, input int win, input int lo_k, input int hi_k, input logic [15:0] p2);
    logic dprev;
    sel = s;
    set_par(s, p);
    res_n = 0; res_load = 0; res_rises = 0;
    res_k[0] = -1; res_k[1] = -1; res_v[0] = '0; res_v[1] = '0;
    res_busy1 = 1'b0; res_busy_v = 1'b1;
    dprev = 1'b0;
    @(negedge clk);
    tog(s, 1'b1);
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      if (!obs_load_n) res_load++;
      if (obs_dclk && !dprev) res_rises++;
      dprev = obs_dclk;
      if (k == 1) res_busy1 = obs_busy;
      if (obs_valid) begin
        if (res_n < 2) begin
          res_k[res_n] = k;
          res_v[res_n] = obs_value;
        end
        if (res_n == 0) res_busy_v = obs_busy;
        res_n++;
      end
      if (k == lo_k) tog(s, 1'b0);
      if (k == hi_k) begin
        tog(s, 1'b1);
        set_par(s, p2);
      end
    end
    res_end = obs_value;
    tog(s, 1'b0);
  endtask
  typedef struct {
    logic [15:0] par;
    bit          v;
    logic [15:0] val;
  } vec_t;
  vec_t tbl [5];
  logic [15:0] b2b_p2, b2b_v0;
  int b2b_n, b2b_k0;
  bit first_after_rst_v;
  initial begin
`ifdef SHIFT_REG_INPUT_DEBOUNCE_EN
    tbl[0] = '{16'h1234, 1'b0, 16'h0000};
    tbl[1] = '{16'h1235, 1'b0, 16'h0000};
    tbl[2] = '{16'h1235, 1'b1, 16'h1235};
    tbl[3] = '{16'hA5C3, 1'b0, 16'h1235};
    tbl[4] = '{16'hA5C3, 1'b1, 16'hA5C3};
    b2b_p2 = 16'hFFFF; b2b_n = 1; b2b_k0 = 258; b2b_v0 = 16'hFFFF;
    first_after_rst_v = 1'b0;
`else
    tbl[0] = '{16'h1234, 1'b1, 16'h1234};
    tbl[1] = '{16'h1235, 1'b1, 16'h1235};
    tbl[2] = '{16'h1235, 1'b1, 16'h1235};
    tbl[3] = '{16'hA5C3, 1'b1, 16'hA5C3};
    tbl[4] = '{16'hA5C3, 1'b1, 16'hA5C3};
    b2b_p2 = 16'h0001; b2b_n = 2; b2b_k0 = 129; b2b_v0 = 16'hFFFF;
    first_after_rst_v = 1'b1;
`endif
    rst_n = 1'b0;
    bus_a.i_enable_toggle = 1'b0;
    bus_b.i_enable_toggle = 1'b0;
    repeat (3) @(negedge clk);
    check("reset load_n", 32'(bus_a.o_load_n), 32'd1);
    check("reset data_clock", 32'(bus_a.o_data_clock), 32'd0);
    check("reset value", 32'(bus_a.o_value), 32'd0);
    check("reset valid", 32'(bus_a.o_valid), 32'd0);
    check("reset busy", 32'(bus_a.o_busy), 32'd0);
    check("reset value b", 32'(bus_b.o_value), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      run_read(1'b0, tbl[i].par, 140, -1, -1, 16'h0);
      check($sformatf("vec%0d valid count", i), 32'(res_n), 32'(tbl[i].v));
      if (tbl[i].v) begin
        check($sformatf("vec%0d latency", i), 32'(res_k[0]), 32'd129);
        check($sformatf("vec%0d value at valid", i), 32'(res_v[0]), 32'(tbl[i].val));
        check($sformatf("vec%0d busy at valid", i), 32'(res_busy_v), 32'd0);
      end
      check($sformatf("vec%0d load_n low cycles", i), 32'(res_load), 32'd4);
      check($sformatf("vec%0d rising edges", i), 32'(res_rises), 32'd15);
      check($sformatf("vec%0d busy first cycle", i), 32'(res_busy1), 32'd1);
      check($sformatf("vec%0d held value", i), 32'(res_end), 32'(tbl[i].val));
      check($sformatf("vec%0d busy after", i), 32'(bus_a.o_busy), 32'd0);
    end
    run_read(1'b0, 16'hA5C3, 200, 36, 39, 16'hA5C3);
    check("retrigger valid count", 32'(res_n), 32'd1);
    check("retrigger latency", 32'(res_k[0]), 32'd129);
    check("retrigger value", 32'(res_v[0]), 32'hA5C3);
    check("retrigger load_n low cycles", 32'(res_load), 32'd4);
    run_read(1'b0, 16'hFFFF, 270, 126, 129, b2b_p2);
    check("b2b valid count", 32'(res_n), 32'(b2b_n));
    check("b2b first valid cycle", 32'(res_k[0]), 32'(b2b_k0));
    check("b2b first value", 32'(res_v[0]), 32'(b2b_v0));
    check("b2b final value", 32'(res_end), 32'(b2b_p2));
    check("b2b load_n low cycles", 32'(res_load), 32'd8);
    if (b2b_n == 2) begin
      check("b2b second valid cycle", 32'(res_k[1]), 32'd258);
      check("b2b second value", 32'(res_v[1]), 32'h0001);
    end
    sel = 1'b0;
    par_a = 16'hA5C3;
    @(negedge clk);
    bus_a.i_enable_toggle = 1'b1;
    repeat (60) @(negedge clk);
    check("pre-reset busy", 32'(bus_a.o_busy), 32'd1);
    rst_n = 1'b0;
    bus_a.i_enable_toggle = 1'b0;
    #1;
    check("midreset load_n", 32'(bus_a.o_load_n), 32'd1);
    check("midreset data_clock", 32'(bus_a.o_data_clock), 32'd0);
    check("midreset value", 32'(bus_a.o_value), 32'd0);
    check("midreset busy", 32'(bus_a.o_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    res_n = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (bus_a.o_valid) res_n++;
    end
    check("no valid after abort", 32'(res_n), 32'd0);
    check("idle after abort", 32'(bus_a.o_busy), 32'd0);
    run_read(1'b0, 16'h5A5A, 140, -1, -1, 16'h0);
    check("post-reset first valid count", 32'(res_n), 32'(first_after_rst_v));
    run_read(1'b0, 16'h5A5A, 140, -1, -1, 16'h0);
    check("post-reset valid count", 32'(res_n), 32'd1);
    check("post-reset latency", 32'(res_k[0]), 32'd129);
    check("post-reset value", 32'(res_v[0]), 32'h5A5A);
    run_read(1'b1, 16'h005A, 60, -1, -1, 16'h0);
    check("small first valid count", 32'(res_n), 32'(first_after_rst_v));
    run_read(1'b1, 16'h005A, 60, -1, -1, 16'h0);
    check("small valid count", 32'(res_n), 32'd1);
    check("small latency", 32'(res_k[0]), 32'd49);
    check("small value", 32'(res_v[0]), 32'h005A);
    check("small load_n low cycles", 32'(res_load), 32'd3);
    check("small rising edges", 32'(res_rises), 32'd7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_reg_input.md
Name: shift_reg_input

Overview:
Reader counterpart to shift_reg_output. It drives a 74HC165-style parallel-in/serial-out register: it pulses the load line, clocks the bits out MSB first, and samples the serial data pin. The result is presented as a parallel word with a one-cycle valid strobe. It sits beside shift_reg_output in top-level designs to read buttons or DIP switches on the TinyFPGA BX, and is started by a counter bit exactly like the output register.

Parameters:
DATA_WIDTH, 4, log2 of word length; N = 2**DATA_WIDTH bits (default 16)
HALF_PERIOD, 4, system clocks per load-pulse and per serial-clock half phase; must be >= 3

Ports:
i_clk  input  1  system clock (16 MHz on the board)
i_reset_n  input  1  asynchronous, active-low reset
i_enable_toggle  input  1  a rising edge (0->1 between consecutive clocks) starts one read
i_data_val  input  1  serial data from the register's Q7 pin; asynchronous to i_clk
o_load_n  output  1  parallel-load strobe to the register, active low
o_data_clock  output  1  serial shift clock to the register
o_value  output  N  last accepted word; bit N-1 is the first bit shifted in
o_valid  output  1  one-cycle pulse when o_value updates
o_busy  output  1  high from LOAD through the final sample

Behaviour:
- Reset values (async assert, sync release): o_load_n=1, o_data_clock=0, o_value=0, o_valid=0, o_busy=0, state=IDLE, all counters 0, edge-detect register 0, synchronizer flops 0.
- i_data_val passes through a 2-flop synchronizer. All samples use the synchronized value.
- Edge detect: register i_enable_toggle every cycle. A start is recognized at cycle T when the registered value is 0 and the input is 1.
- IDLE: on start, move to LOAD at T+1. A start seen in any other state is dropped, not queued.
- LOAD: o_load_n=0 for HALF_PERIOD cycles, o_busy=1, then move to SHIFT_LOW with bit index=0.
- SHIFT_LOW: o_data_clock=0 for HALF_PERIOD cycles. On the last cycle, shift the synchronized data into the raw word: raw = {raw[N-2:0], data}. If index==N-1, move to DONE; otherwise move to SHIFT_HIGH.
- SHIFT_HIGH: o_data_clock=1 for HALF_PERIOD cycles, increment index, return to SHIFT_LOW. This phase is skipped after the last bit, so there are exactly N-1 rising edges on o_data_clock.
- DONE (1 cycle): o_value<=raw, o_valid=1 in this cycle, o_busy=0, then return to IDLE. The next start may be recognized in this same cycle.
- Latency: LOAD is entered at T+1 and o_valid is high at cycle T+1+2*N*HALF_PERIOD. For the defaults this is T+129.
- Phase counter width is clog2(HALF_PERIOD). Index width is DATA_WIDTH; there is no wrap inside a read.
- o_value holds its value between reads. It is never partially updated.
- Reset mid-read: the read is abandoned, all outputs take their reset values, and no o_valid is produced.

Optional Feature:
SHIFT_REG_INPUT_DEBOUNCE_EN. When defined, the block keeps the previous raw word (reset 0). In DONE it updates o_value and pulses o_valid only if raw equals the previous raw; the previous raw always updates to the new raw. Two identical consecutive reads are therefore required. An all-zero word is accepted on the first read after reset. When undefined, every completed read updates o_value and pulses o_valid, and the previous-word register does not exist.

Decomposition:
- shift_reg_pkg: state encoding (IDLE, LOAD, SHIFT_LOW, SHIFT_HIGH, DONE) and a helper for N from DATA_WIDTH. shift_reg_output also uses this helper.
- Sub-module bit_synchronizer: 2-flop synchronizer with async active-low reset. It is reusable for other external inputs.

Test Plan:
- Behavioural 165 model loaded with 0xA5C3; toggle i_enable_toggle 0->1 -> o_load_n low 4 cycles, 15 rising o_data_clock edges, o_value=0xA5C3 with o_valid at T+129, o_busy low afterwards.
- Retrigger: pulse i_enable_toggle again at T+40 during a read -> ignored; exactly one o_valid; o_value=0xA5C3.
- Back-to-back: model value 0xFFFF then 0x0001; trigger in the DONE cycle -> second read starts at once, o_value=0xFFFF then 0x0001.
- Reset: assert i_reset_n=0 at T+60 of a read -> outputs immediately o_load_n=1, o_data_clock=0, o_value=0; no o_valid; next read returns the correct word.
- Parameter sweep DATA_WIDTH=3, HALF_PERIOD=3, value 0x5A -> o_valid at T+1+48, o_value=0x5A.
- SHIFT_REG_INPUT_DEBOUNCE_EN defined: reads 0x1234, 0x1235, 0x1235 -> o_valid only on the third read, o_value=0x1235. Undefined: o_valid on all three reads.
